// File: rtl/mips_avalon_bridge_if.sv
// Avalon-MM master bus bundle between the MIPS bridge and the memory fabric.
interface mips_avalon_bridge_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  read;
    logic                  write;
    logic                  waitrequest;
    logic [31:0]           writedata;
    logic [3:0]            byteenable;
    logic [31:0]           readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/mips_avalon_bridge.sv
// Arbitrates MIPS fetch and load/store requests onto one Avalon-MM master port.
// Optional macro MIPS_BRIDGE_MISALIGN_TRAP_EN: misaligned loads/stores complete with data_error instead of a bus cycle.
module mips_avalon_bridge #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_PRIORITY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_req,
    input  logic [ADDR_WIDTH-1:0] instr_address,
    output logic                  instr_valid,
    output logic [31:0]           instr_readdata,
    input  logic                  data_read,
    input  logic                  data_write,
    input  logic [1:0]            data_size,
    input  logic                  data_signed,
    input  logic [ADDR_WIDTH-1:0] data_address,
    input  logic [31:0]           data_writedata,
    output logic [31:0]           data_readdata,
    output logic                  data_done,
    output logic                  data_error,
    mips_avalon_bridge_if.master  avm,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, IFETCH, DREAD, DWRITE} state_t;

    state_t                state_reg, state_next;
    logic                  read_reg, read_next;
    logic                  write_reg, write_next;
    logic [ADDR_WIDTH-1:0] address_reg, address_next;
    logic [3:0]            byteenable_reg, byteenable_next;
    logic [31:0]           writedata_reg, writedata_next;
    logic                  instr_valid_reg, instr_valid_next;
    logic [31:0]           instr_readdata_reg, instr_readdata_next;
    logic                  data_done_reg, data_done_next;
    logic [31:0]           data_readdata_reg, data_readdata_next;
    logic [1:0]            off_reg, off_next;
    logic [1:0]            size_reg, size_next;
    logic                  signed_reg, signed_next;
    logic                  starve_i_reg, starve_i_next;
    logic                  starve_d_reg, starve_d_next;

    logic        instr_ok, data_ok, pick_data, accept_instr, accept_data, trap;
    logic [1:0]  req_off;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [15:0] lane16;
    logic [31:0] load_ext;

    // A side whose completion pulse is on the wire is masked so a held request is not re-run.
    assign instr_ok = instr_req && !instr_valid_reg;
    assign data_ok  = (data_read || data_write) && !data_done_reg;

    always_comb begin
        pick_data = data_ok;
        if (instr_ok && data_ok) begin
            if (starve_i_reg)      pick_data = 1'b0;
            else if (starve_d_reg) pick_data = 1'b1;
            else                   pick_data = (DATA_PRIORITY != 0);
        end
    end

    assign accept_data  = (state_reg == IDLE) && data_ok && pick_data;
    assign accept_instr = (state_reg == IDLE) && instr_ok && !pick_data;

    // Lane offset, byteenable and replicated store data for the pending data request.
    always_comb begin
        case (data_size)
            2'b00: begin
                req_off   = data_address[1:0];
                req_be    = 4'b0001 << data_address[1:0];
                req_wdata = {4{data_writedata[7:0]}};
            end
            2'b01: begin
                req_off   = {data_address[1], 1'b0};
                req_be    = 4'b0011 << {data_address[1], 1'b0};
                req_wdata = {2{data_writedata[15:0]}};
            end
            default: begin
                req_off   = 2'b00;
                req_be    = 4'b1111;
                req_wdata = data_writedata;
            end
        endcase
    end

`ifdef MIPS_BRIDGE_MISALIGN_TRAP_EN
    logic req_misalign;
    logic data_error_reg;

    always_comb begin
        case (data_size)
            2'b00:   req_misalign = 1'b0;
            2'b01:   req_misalign = data_address[0];
            default: req_misalign = |data_address[1:0];
        endcase
    end

    assign trap = accept_data && req_misalign;

    always_ff @(posedge clk) begin
        if (reset) data_error_reg <= 1'b0;
        else       data_error_reg <= trap;
    end

    assign data_error = data_error_reg;
`else
    assign trap       = 1'b0;
    assign data_error = 1'b0;
`endif

    // Load path: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        case (off_reg)
            2'd0:    lane16 = avm.readdata[15:0];
            2'd1:    lane16 = avm.readdata[23:8];
            2'd2:    lane16 = avm.readdata[31:16];
            default: lane16 = {8'h00, avm.readdata[31:24]};
        endcase
        case (size_reg)
            2'b00:   load_ext = {{24{signed_reg & lane16[7]}}, lane16[7:0]};
            2'b01:   load_ext = {{16{signed_reg & lane16[15]}}, lane16};
            default: load_ext = avm.readdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= IDLE;
            read_reg           <= 1'b0;
            write_reg          <= 1'b0;
            address_reg        <= '0;
            byteenable_reg     <= 4'b0000;
            writedata_reg      <= 32'd0;
            instr_valid_reg    <= 1'b0;
            instr_readdata_reg <= 32'd0;
            data_done_reg      <= 1'b0;
            data_readdata_reg  <= 32'd0;
            off_reg            <= 2'b00;
            size_reg           <= 2'b00;
            signed_reg         <= 1'b0;
            starve_i_reg       <= 1'b0;
            starve_d_reg       <= 1'b0;
        end else begin
            state_reg          <= state_next;
            read_reg           <= read_next;
            write_reg          <= write_next;
            address_reg        <= address_next;
            byteenable_reg     <= byteenable_next;
            writedata_reg      <= writedata_next;
            instr_valid_reg    <= instr_valid_next;
            instr_readdata_reg <= instr_readdata_next;
            data_done_reg      <= data_done_next;
            data_readdata_reg  <= data_readdata_next;
            off_reg            <= off_next;
            size_reg           <= size_next;
            signed_reg         <= signed_next;
            starve_i_reg       <= starve_i_next;
            starve_d_reg       <= starve_d_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept_instr)             state_next = IFETCH;
                else if (accept_data && !trap) state_next = data_write ? DWRITE : DREAD;
            end
            IFETCH, DREAD, DWRITE: begin
                if (!avm.waitrequest) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        read_next           = read_reg;
        write_next          = write_reg;
        address_next        = address_reg;
        byteenable_next     = byteenable_reg;
        writedata_next      = writedata_reg;
        instr_valid_next    = 1'b0;
        instr_readdata_next = instr_readdata_reg;
        data_done_next      = 1'b0;
        data_readdata_next  = data_readdata_reg;
        off_next            = off_reg;
        size_next           = size_reg;
        signed_next         = signed_reg;
        starve_i_next       = starve_i_reg;
        starve_d_next       = starve_d_reg;
        case (state_reg)
            IDLE: begin
                read_next  = 1'b0;
                write_next = 1'b0;
                if (accept_instr) begin
                    address_next    = instr_address;
                    byteenable_next = 4'b1111;
                    read_next       = 1'b1;
                    starve_i_next   = 1'b0;
                    if (data_ok) starve_d_next = 1'b1;
                end else if (accept_data) begin
                    starve_d_next = 1'b0;
                    if (instr_ok) starve_i_next = 1'b1;
                    if (trap) begin
                        data_done_next     = 1'b1;
                        data_readdata_next = 32'd0;
                    end else begin
                        address_next    = {data_address[ADDR_WIDTH-1:2], 2'b00};
                        byteenable_next = req_be;
                        writedata_next  = req_wdata;
                        read_next       = !data_write;
                        write_next      = data_write;
                        off_next        = req_off;
                        size_next       = data_size;
                        signed_next     = data_signed;
                    end
                end
            end
            IFETCH: begin
                if (!avm.waitrequest) begin
                    read_next           = 1'b0;
                    instr_valid_next    = 1'b1;
                    instr_readdata_next = avm.readdata;
                end
            end
            DREAD: begin
                if (!avm.waitrequest) begin
                    read_next          = 1'b0;
                    data_done_next     = 1'b1;
                    data_readdata_next = load_ext;
                end
            end
            DWRITE: begin
                if (!avm.waitrequest) begin
                    write_next     = 1'b0;
                    data_done_next = 1'b1;
                end
            end
            default: begin
                read_next  = 1'b0;
                write_next = 1'b0;
            end
        endcase
    end

    assign avm.address     = address_reg;
    assign avm.read        = read_reg;
    assign avm.write       = write_reg;
    assign avm.byteenable  = byteenable_reg;
    assign avm.writedata   = writedata_reg;
    assign instr_valid     = instr_valid_reg;
    assign instr_readdata  = instr_readdata_reg;
    assign data_done       = data_done_reg;
    assign data_readdata   = data_readdata_reg;
    assign busy            = (state_reg != IDLE);

endmodule

// File: tb/tb_mips_avalon_bridge.sv
// Directed and randomized checks of mips_avalon_bridge against a lane/extension model of the bus rules.
module tb_mips_avalon_bridge;

`ifdef MIPS_BRIDGE_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        instr_req;
    logic [31:0] instr_address;
    logic        instr_valid;
    logic [31:0] instr_readdata;
    logic        data_read;
    logic        data_write;
    logic [1:0]  data_size;
    logic        data_signed;
    logic [31:0] data_address;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        data_done;
    logic        data_error;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mips_avalon_bridge_if #(.ADDR_WIDTH(32)) avm ();

    mips_avalon_bridge #(.ADDR_WIDTH(32), .DATA_PRIORITY(1)) dut (
        .clk            (clk),
        .reset          (reset),
        .instr_req      (instr_req),
        .instr_address  (instr_address),
        .instr_valid    (instr_valid),
        .instr_readdata (instr_readdata),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_size      (data_size),
        .data_signed    (data_signed),
        .data_address   (data_address),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata),
        .data_done      (data_done),
        .data_error     (data_error),
        .avm            (avm.master),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference rules, written with plain arithmetic on byte offsets.
    function automatic int unsigned offset_of(logic [1:0] sz, logic [31:0] a);
        if (sz == 2'b00) return a % 4;
        if (sz == 2'b01) return ((a % 4) >= 2) ? 2 : 0;
        return 0;
    endfunction

    function automatic logic [31:0] exp_be(logic [1:0] sz, logic [31:0] a);
        if (sz == 2'b00) return 32'd1 << offset_of(sz, a);
        if (sz == 2'b01) return 32'd3 << offset_of(sz, a);
        return 32'd15;
    endfunction

    function automatic logic [31:0] exp_wd(logic [1:0] sz, logic [31:0] w);
        if (sz == 2'b00) return (w & 32'hFF) * 32'h01010101;
        if (sz == 2'b01) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] exp_load(logic [1:0] sz, bit sgn, logic [31:0] a, logic [31:0] rd);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = (rd >> (8 * offset_of(sz, a))) & 32'hFF;
            if (sgn && v >= 128) v = v | 32'hFFFFFF00;
            return v;
        end
        if (sz == 2'b01) begin
            v = (rd >> (8 * offset_of(sz, a))) & 32'hFFFF;
            if (sgn && v >= 32768) v = v | 32'hFFFF0000;
            return v;
        end
        return rd;
    endfunction

    function automatic bit misaligned(logic [1:0] sz, logic [31:0] a);
        if (sz == 2'b00) return 1'b0;
        if (sz == 2'b01) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    task automatic do_fetch(input logic [31:0] a, input int nwait, input logic [31:0] rd);
        int strobes;
        int done_at;
        strobes = 0;
        done_at = -1;
        instr_req     = 1'b1;
        instr_address = a;
        avm.readdata  = rd;
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            @(posedge clk); #1;
            if (avm.read || avm.write) begin
                strobes++;
                chk("fetch_rw", {30'd0, avm.read, avm.write}, 32'd2);
                chk("fetch_addr", avm.address, a);
                chk("fetch_be", 32'(avm.byteenable), 32'hF);
                avm.waitrequest = (strobes <= nwait);
            end else begin
                avm.waitrequest = 1'($urandom_range(0, 1));
            end
            if (instr_valid) done_at = c;
        end
        chk("fetch_latency", done_at, nwait + 2);
        chk("fetch_strobes", strobes, nwait + 1);
        chk("fetch_data", instr_readdata, rd);
        chk("fetch_no_data_done", 32'(data_done), 32'd0);
        @(posedge clk); #1;
        chk("fetch_no_reaccept", {28'd0, busy, avm.read, avm.write, instr_valid}, 32'd0);
        instr_req = 1'b0;
        $display("txn fetch addr=%h wait=%0d data=%h", a, nwait, instr_readdata);
    endtask

    task automatic do_data(input bit wr, input logic [1:0] sz, input bit sgn, input logic [31:0] a,
                           input logic [31:0] wd, input int nwait, input logic [31:0] rd);
        int strobes;
        int done_at;
        bit trap;
        trap    = TRAP && misaligned(sz, a);
        strobes = 0;
        done_at = -1;
        data_read      = !wr;
        data_write     = wr;
        data_size      = sz;
        data_signed    = sgn;
        data_address   = a;
        data_writedata = wd;
        avm.readdata   = rd;
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            @(posedge clk); #1;
            if (avm.read || avm.write) begin
                strobes++;
                chk("data_rw", {30'd0, avm.read, avm.write}, wr ? 32'd1 : 32'd2);
                chk("data_addr", avm.address, a & ~32'h3);
                chk("data_be", 32'(avm.byteenable), exp_be(sz, a));
                if (wr) chk("data_wd", avm.writedata, exp_wd(sz, wd));
                avm.waitrequest = (strobes <= nwait);
            end else begin
                avm.waitrequest = 1'($urandom_range(0, 1));
            end
            if (data_done) done_at = c;
        end
        chk("data_latency", done_at, trap ? 32'd1 : nwait + 2);
        chk("data_strobes", strobes, trap ? 32'd0 : nwait + 1);
        chk("data_error", 32'(data_error), 32'(trap));
        if (!wr) chk("data_load", data_readdata, trap ? 32'd0 : exp_load(sz, sgn, a, rd));
        chk("data_no_instr_valid", 32'(instr_valid), 32'd0);
        @(posedge clk); #1;
        chk("data_no_reaccept", {28'd0, busy, avm.read, avm.write, data_done}, 32'd0);
        data_read  = 1'b0;
        data_write = 1'b0;
        $display("txn %s size=%0d signed=%0d addr=%h wd=%h wait=%0d rd=%h -> %h err=%0d",
                 wr ? "store" : "load", sz, sgn, a, wd, nwait, rd, data_readdata, data_error);
    endtask

    initial begin
        int kind;
        int nw;
        logic [31:0] ra, rw, rr;
        logic [1:0] rs;
        bit rg;

        reset          = 1'b1;
        instr_req      = 1'b0;
        instr_address  = 32'd0;
        data_read      = 1'b0;
        data_write     = 1'b0;
        data_size      = 2'b00;
        data_signed    = 1'b0;
        data_address   = 32'd0;
        data_writedata = 32'd0;
        avm.waitrequest = 1'b0;
        avm.readdata    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {26'd0, avm.read, avm.write, instr_valid, data_done, data_error, busy}, 32'd0);
        chk("reset_addr", avm.address, 32'd0);
        chk("reset_wd", avm.writedata, 32'd0);
        chk("reset_be", 32'(avm.byteenable), 32'd0);
        chk("reset_ird", instr_readdata, 32'd0);
        chk("reset_drd", data_readdata, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_fetch(32'h0000_0040, 0, 32'h8C22_0004);
        do_data(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00AB, 0, 32'd0);
        do_data(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'd0, 3, 32'h80FF_1234);
        do_data(1'b1, 2'b10, 1'b0, 32'h0000_3001, 32'h1234_5678, 0, 32'd0);
        do_data(1'b0, 2'b11, 1'b0, 32'h0000_0008, 32'd0, 1, 32'hCAFE_F00D);

        // Simultaneous fetch and load: data wins, fetch follows after one idle cycle.
        instr_req      = 1'b1;
        instr_address  = 32'h0000_0100;
        data_read      = 1'b1;
        data_size      = 2'b10;
        data_signed    = 1'b0;
        data_address   = 32'h0000_2004;
        avm.readdata   = 32'h1111_2222;
        avm.waitrequest = 1'b0;
        @(posedge clk); #1;
        chk("arb_first_read", {30'd0, avm.read, avm.write}, 32'd2);
        chk("arb_first_addr", avm.address, 32'h0000_2004);
        @(posedge clk); #1;
        chk("arb_data_done", {29'd0, data_done, instr_valid, busy}, 32'd4);
        chk("arb_data_rd", data_readdata, 32'h1111_2222);
        data_read    = 1'b0;
        avm.readdata = 32'h3333_4444;
        @(posedge clk); #1;
        chk("arb_second_read", {30'd0, avm.read, avm.write}, 32'd2);
        chk("arb_second_addr", avm.address, 32'h0000_0100);
        @(posedge clk); #1;
        chk("arb_instr_valid", 32'(instr_valid), 32'd1);
        chk("arb_instr_rd", instr_readdata, 32'h3333_4444);
        $display("txn arbitration load@2004 then fetch@100");
        @(posedge clk); #1;
        instr_req = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a stalled write drops the transaction silently.
        data_write      = 1'b1;
        data_size       = 2'b10;
        data_address    = 32'h0000_4000;
        data_writedata  = 32'hDEAD_BEEF;
        avm.waitrequest = 1'b1;
        @(posedge clk); #1;
        chk("rst_write_hi", 32'(avm.write), 32'd1);
        @(posedge clk); #1;
        chk("rst_write_held", 32'(avm.write), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ctrl", {28'd0, avm.write, avm.read, busy, data_done}, 32'd0);
        chk("rst_mid_addr", avm.address, 32'd0);
        data_write = 1'b0;
        reset      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_no_done", {30'd0, data_done, avm.write}, 32'd0);
        end
        $display("txn reset during stalled store");

        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 2);
            nw   = $urandom_range(0, 3);
            ra   = {16'h0000, 16'($urandom)};
            rw   = $urandom;
            rr   = $urandom;
            rs   = 2'($urandom_range(0, 3));
            rg   = 1'($urandom_range(0, 1));
            if (kind == 0) do_fetch(ra & ~32'h3, nw, rr);
            else           do_data(kind == 2, rs, rg, ra, rw, nw, rr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_avalon_bridge.md
MIPS_AVALON_BRIDGE -- requirements
Module: mips_avalon_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: Avalon and core address width, legal range 8..32.
REQ-002 SHALL have parameter DATA_PRIORITY, default 1: on a simultaneous request, 1 = data side wins, 0 = instruction side wins.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high.
REQ-005 SHALL have port instr_req, input, 1: fetch request; held high by the core until instr_valid.
REQ-006 SHALL have port instr_address, input, ADDR_WIDTH: fetch address, word aligned.
REQ-007 SHALL have port instr_valid, output, 1: one-cycle pulse; instr_readdata is valid in the same cycle.
REQ-008 SHALL have port instr_readdata, output, 32: fetched word.
REQ-009 SHALL have port data_read / data_write, input, 1 each: load/store request, mutually exclusive, held until data_done.
REQ-010 SHALL have port data_size, input, 2: 00 byte, 01 halfword, 10 word; 11 is treated as word.
REQ-011 SHALL have port data_signed, input, 1: sign-extend a byte/halfword load; 0 zero-extends.
REQ-012 SHALL have ports data_address (input, ADDR_WIDTH), data_writedata (input, 32; store value right-aligned), data_readdata (output, 32; extended load result), data_done (output, 1; one-cycle completion pulse) and data_error (output, 1; valid with data_done).
REQ-013 SHALL have Avalon master ports address (out, ADDR_WIDTH), read, write (out, 1), waitrequest (in, 1), writedata (out, 32), byteenable (out, 4), readdata (in, 32).
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, IFETCH, DREAD, DWRITE.
REQ-016 In IDLE with a request pending, SHALL latch the address, size, sign and write data, and enter the bus state at the next edge; simultaneous requests are resolved by DATA_PRIORITY.
REQ-017 SHALL register all Avalon outputs; read/write SHALL be high for exactly the cycles spent in IFETCH/DREAD and DWRITE, with address, byteenable and writedata held constant.
REQ-018 SHALL remain in a bus state while waitrequest=1; in the first cycle with waitrequest=0 it SHALL capture readdata and return to IDLE at the next edge.
REQ-019 SHALL assert instr_valid or data_done in the cycle after completion; minimum latency from request to done is 2 cycles; back-to-back transactions SHALL leave one IDLE cycle between them.
REQ-020 Bus address SHALL be {data_address[ADDR_WIDTH-1:2], 2'b00}; fetch address SHALL be passed through unchanged.
REQ-021 Byteenable and store lanes: byte -> 0001 << addr[1:0], data replicated to all four lanes; halfword -> 0011 << {addr[1],1'b0}, data replicated to both halves; word -> 1111.
REQ-022 Loads SHALL shift the selected lane to bit 0, then sign- or zero-extend per data_signed; a word load SHALL be passed through unchanged.
REQ-023 A request deasserted mid-transaction SHALL NOT abort the transaction; the done pulse is still issued.
REQ-024 A request still asserted in the cycle done is pulsed SHALL NOT be re-accepted; the core must drop it or treat it as a new request after the pulse.
REQ-025 The losing side of arbitration SHALL be served next, ahead of any new request from the winner (no starvation).

Reset
REQ-026 On reset, SHALL enter IDLE at the next edge and drive read, write, instr_valid, data_done, data_error and busy to 0; address, writedata, byteenable, instr_readdata and data_readdata to 0.
REQ-027 A reset during a bus state SHALL drop read/write at the next edge and discard the transaction without a done pulse.

Configuration
REQ-028 With MIPS_BRIDGE_MISALIGN_TRAP_EN defined: a halfword with addr[0]=1, or a word with addr[1:0]!=0, SHALL issue no bus cycle and SHALL pulse data_done with data_error=1 in the cycle after acceptance; data_readdata is 0 in that case.
REQ-029 Without the macro: data_error SHALL be tied to 0; a misaligned halfword SHALL use lane addr[1], and a misaligned word SHALL use addr[1:0] forced to 00.

Verification
REQ-030 instr_req with address 0x00000040, waitrequest=0, readdata 0x8C220004 -> read high 1 cycle at 0x40, byteenable 1111, instr_valid 2 cycles after request with instr_readdata 0x8C220004.
REQ-031 Byte store at 0x1003 with data_writedata 0x000000AB -> address 0x1000, byteenable 1000, writedata 0xABABABAB, data_done 2 cycles after request.
REQ-032 Signed halfword load at 0x2002 with readdata 0x80FF1234 and waitrequest high 3 cycles -> read held 4 cycles, data_readdata 0xFFFF80FF.
REQ-033 instr_req and data_read asserted in the same cycle, DATA_PRIORITY=1 -> data read served first, then fetch after one IDLE cycle.
REQ-034 Reset asserted while in DWRITE with waitrequest=1 -> write=0 next cycle, no data_done, busy=0.
REQ-035 With the macro, word store at 0x3001 -> no write cycle, data_done=1 and data_error=1 one cycle after the request; without the macro -> write to 0x3000 with byteenable 1111.
